// File: rtl/rom_stream_pkg.sv
// Shared definitions for the ROM stream reader: FSM state encoding and the
// depth of the output buffer between the ROM and the stream interface.
package rom_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_stream_fifo2.sv
// Two-entry FIFO holding {last, data} words between the ROM issue logic and
// the output stream. Entry 0 is always the head, so the stream payload comes
// straight from a register and stays stable while the consumer stalls.
module rom_stream_fifo2
  import rom_stream_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic [1:0]   count_q, count_d;
  logic [1:0]   level;
  logic         do_push, do_pop;

  // Pop first, then place the pushed word in the first free slot.
  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != FULL) || do_pop);
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    level   = do_pop ? (count_q - 2'd1) : count_q;
    if (do_pop) begin
      mem0_d = mem1_q;
    end
    if (do_push) begin
      if (level == 2'd0) begin
        mem0_d = push_data_i;
      end else begin
        mem1_d = push_data_i;
      end
    end
    count_d = level + (do_push ? 2'd1 : 2'd0);
  end

  // Storage and occupancy registers; reset discards any buffered words.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem0_q;
  assign count_o = count_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Burst sequencer in front of a combinational ROM. A start request turns a
// (base address, word count) pair into consecutive ROM reads whose data is
// buffered in a 2-entry FIFO and delivered as a valid/ready stream with a
// last marker.
// Optional build macro ROM_STREAM_CHECKSUM_EN adds a checksum output holding
// the XOR of every word popped in the current burst.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; zero-length requests only pulse done
// ST_READ  | issuing ROM reads whenever the FIFO has room
// ST_DRAIN | all reads issued; waiting for the last word to handshake
module rom_stream_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_read_en,
  output logic              rom_ce,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef ROM_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  import rom_stream_pkg::*;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   fifo_head;
  logic [1:0]        fifo_count;
  logic              accept, zero_req, issue, last_issue, pop, last_pop;

  // The issue decision uses the registered FIFO count, so a pop in the same
  // cycle does not open a slot until the next cycle.
  assign accept     = (state_q == ST_IDLE) && start && (len != '0);
  assign zero_req   = (state_q == ST_IDLE) && start && (len == '0);
  assign issue      = (state_q == ST_READ) && (int'(fifo_count) < FIFO_DEPTH);
  assign last_issue = issue && (cnt_q == (ADDR_W+1)'(1));
  assign out_valid  = (fifo_count != 2'd0);
  assign pop        = out_valid && out_ready;
  assign last_pop   = pop && fifo_head[DATA_W];

  rom_stream_fifo2 #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (issue),
    .push_data_i ({last_issue, rom_data}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_READ;
      ST_READ:  if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (last_pop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ROM strobes only on an issue; the address bus otherwise
  // keeps the last issued address.
  always_comb begin
    rom_ce      = issue;
    rom_read_en = issue;
    rom_address = issue ? ptr_q : addr_hold_q;
  end

  // Next values for pointer, remaining count, held address and status flags.
  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    addr_hold_d = addr_hold_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    if (accept) begin
      ptr_d  = base_addr;
      cnt_d  = len;
      busy_d = 1'b1;
    end
    if (issue) begin
      ptr_d       = ptr_q + ADDR_W'(1);
      cnt_d       = cnt_q - (ADDR_W+1)'(1);
      addr_hold_d = ptr_q;
    end
    if (zero_req) begin
      done_d = 1'b1;
    end
    if (last_pop) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      addr_hold_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      addr_hold_q <= addr_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = fifo_head[DATA_W-1:0];
  assign out_last = out_valid && fifo_head[DATA_W];

`ifdef ROM_STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Running XOR of popped words, restarted by every request taken in IDLE.
  always_comb begin
    csum_d = csum_q;
    if ((state_q == ST_IDLE) && start) begin
      csum_d = '0;
    end else if (pop) begin
      csum_d = csum_q ^ fifo_head[DATA_W-1:0];
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader. A negedge monitor keeps a
// transaction-level model (expected word queue, address sequence, busy/done
// expectations) and compares every cycle; the main process runs directed
// scenarios followed by randomized bursts with random backpressure.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] len = '0;
  logic       busy, done;
  logic [7:0] rom_address;
  logic       rom_read_en, rom_ce;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
`ifdef ROM_STREAM_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  logic [7:0] rom [256];
  assign rom_data = rom[rom_address];

  always #5 clk = ~clk;

  rom_stream_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_read_en (rom_read_en),
    .rom_ce      (rom_ce),
    .rom_data    (rom_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
`ifdef ROM_STREAM_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 0: always ready, 1: never ready, 2: random
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model state
  bit         mon_en = 0;
  bit         m_busy = 0;
  bit         m_done = 0;
  logic [8:0] expq[$];
  logic [7:0] m_addr = '0;
  logic [7:0] m_hold = '0;
  int         m_rem = 0;
  logic [7:0] m_csum = '0;
  int         occ = 0;
  bit         prev_stall = 0;
  logic [8:0] prev_word = '0;
  int         issue_cnt = 0;
  int         pop_cnt = 0;
  logic [7:0] addr_log[$];

  always @(negedge clk) begin
    if (mon_en) begin : mon
      bit was_busy;
      logic [8:0] e;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
`ifdef ROM_STREAM_CHECKSUM_EN
      chk("checksum", checksum, m_csum);
`endif
      if (!m_busy) begin
        chk("idle_valid", out_valid, 0);
        chk("idle_ce", rom_ce, 0);
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", {out_last, out_data}, prev_word);
      end
      if (!rom_ce) chk("addr_hold", rom_address, m_hold);
      was_busy = m_busy;
      m_done = 0;
      if (reset) begin
        m_busy = 0;
        expq.delete();
        occ = 0;
        m_rem = 0;
        m_csum = '0;
        m_hold = '0;
        prev_stall = 0;
      end else begin
        if (rom_ce) begin
          issue_cnt++;
          addr_log.push_back(rom_address);
          chk("rd_en", rom_read_en, 1);
          chk("rom_addr", rom_address, m_addr);
          chk("issue_budget", m_rem > 0, 1);
          m_hold = rom_address;
          m_addr = m_addr + 8'd1;
          m_rem--;
          occ++;
        end
        if (out_valid && out_ready) begin
          pop_cnt++;
          occ--;
          chk("word_expected", expq.size() != 0, 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("word", {out_last, out_data}, e);
            m_csum = m_csum ^ out_data;
            if (e[8]) begin
              m_busy = 0;
              m_done = 1;
            end
          end
        end
        chk("fifo_occ_le2", occ <= 2, 1);
        prev_stall = out_valid && !out_ready;
        prev_word = {out_last, out_data};
        if (!was_busy && start) begin
          m_csum = '0;
          if (len != 0) begin
            m_busy = 1;
            m_addr = base_addr;
            m_rem = int'(len);
            for (int i = 0; i < int'(len); i++)
              expq.push_back({1'(i == int'(len) - 1), rom[8'(int'(base_addr) + i)]});
          end else begin
            m_done = 1;
          end
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 8'($urandom); len = 9'($urandom);
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < max_cyc);
    chk("done_seen", done, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ic0, pc0, n;
    logic [7:0] exp_a[4];
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_address, 0);
    chk("rst_rd_en", rom_read_en, 0);
    chk("rst_ce", rom_ce, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1;

    // Basic burst with latency and back-to-back delivery
    rdy_mode = 0;
    do_start(8'h10, 9'd4);
    @(negedge clk);
    chk("t1_first_issue", rom_ce, 1);
    chk("t1_not_valid_yet", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 8'h10 + 8'(k));
      chk("t1_last", out_last, k == 3);
    end
    @(negedge clk);
    chk("t1_done", done, 1);

    // Backpressure: only two reads while stalled, head held
    rdy_mode = 1;
    ic0 = issue_cnt;
    pc0 = pop_cnt;
    do_start(8'h00, 9'd6);
    repeat (8) @(negedge clk);
    chk("t2_issues_stalled", issue_cnt - ic0, 2);
    chk("t2_head_data", out_data, 8'h00);
    chk("t2_head_valid", out_valid, 1);
    rdy_mode = 0;
    wait_done(100);
    chk("t2_words", pop_cnt - pc0, 6);

    // Address wrap
    addr_log.delete();
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_start(8'hFE, 9'd4);
    wait_done(100);
    chk("t3_n_addr", addr_log.size(), 4);
    for (int k = 0; k < 4 && k < addr_log.size(); k++) chk("t3_addr_seq", addr_log[k], exp_a[k]);

    // Zero-length request
    ic0 = issue_cnt;
    do_start(8'h33, 9'd0);
    wait_done(3);
    chk("t4_busy", busy, 0);
    @(negedge clk);
    chk("t4_done_once", done, 0);
    chk("t4_no_issue", issue_cnt - ic0, 0);

    // Full address space
    rdy_mode = 2;
    pc0 = pop_cnt;
    do_start(8'h00, 9'd256);
    wait_done(2000);
    chk("t5_words", pop_cnt - pc0, 256);

    // Start pulsed mid-burst is ignored
    do_start(8'h50, 9'd10);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h00; len = 9'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);

    // Reset after the second word
    rdy_mode = 0;
    pc0 = pop_cnt;
    do_start(8'h20, 9'd8);
    n = 0;
    while ((pop_cnt - pc0) < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_two_popped", (pop_cnt - pc0) >= 2, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ce", rom_ce, 0);
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_done", done, 0);
    end
    pc0 = pop_cnt;
    do_start(8'h30, 9'd3);
    wait_done(50);
    chk("t6_fresh_words", pop_cnt - pc0, 3);

`ifdef ROM_STREAM_CHECKSUM_EN
    rom[8'h40] = 8'h01; rom[8'h41] = 8'h02; rom[8'h42] = 8'h04; rom[8'h43] = 8'h08;
    rdy_mode = 2;
    do_start(8'h40, 9'd4);
    wait_done(100);
    chk("cs_final", checksum, 8'h0F);
    repeat (6) begin
      @(negedge clk);
      chk("cs_held", checksum, 8'h0F);
    end
    do_start(8'h00, 9'd2);
    @(negedge clk);
    chk("cs_cleared", checksum, 8'h00);
    wait_done(50);
`endif

    // Randomized bursts over random ROM contents
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int it = 0; it < 15; it++) begin
      rdy_mode = (($urandom_range(0, 1)) != 0) ? 2 : 0;
      pc0 = pop_cnt;
      n = $urandom_range(1, 24);
      do_start(8'($urandom), 9'(n));
      if (n >= 3 && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_done(500);
      chk("rand_words", pop_cnt - pc0, n);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Sequencer that sits directly upstream of the 8-bit ROM.
- Turns a one-shot request (base address, word count) into a burst of ROM reads, driving the ROM's address/read_en/ce and sampling its combinational data output.
- Delivers the words as a valid/ready stream with a last marker, buffered in a 2-entry FIFO so downstream backpressure never loses data.

Parameters:
- ADDR_W, 8, ROM address width; the address space is 2^ADDR_W words.
- DATA_W, 8, ROM data width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first ROM address of the burst.
- len  in  ADDR_W+1  number of words to read (0..2^ADDR_W).
- busy  out  1  high from request acceptance until the last word is popped.
- done  out  1  one-cycle completion pulse.
- rom_address  out  ADDR_W  to ROM address.
- rom_read_en  out  1  to ROM read_en.
- rom_ce  out  1  to ROM ce.
- rom_data  in  DATA_W  from ROM data (combinational, valid in the same cycle as the address).
- out_data  out  DATA_W  stream payload (FIFO head).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks the final word of the burst.

Behaviour:
- Reset values: busy=0, done=0, rom_address=0, rom_read_en=0, rom_ce=0, out_valid=0, out_last=0, out_data=0, FIFO count=0, state=IDLE.
- States: IDLE, READ, DRAIN.
- IDLE:
  - start=1 and len!=0: latch the address pointer = base_addr and the remaining-issue counter = len; go to READ; busy=1 from the next cycle.
  - start=1 and len=0: done=1 for one cycle in the next cycle; no ROM access; busy stays 0.
- READ, issue rule:
  - Issue when the registered FIFO count < 2.
  - An issue drives rom_ce=rom_read_en=1 and rom_address=pointer, and pushes rom_data into the FIFO at that clock edge.
  - After an issue, pointer increments modulo 2^ADDR_W and the counter decrements.
  - The issue that takes the counter to 0 tags its FIFO entry last=1 and moves the state to DRAIN.
- When not issuing: rom_ce=rom_read_en=0 and rom_address holds its previous value.
- DRAIN: when the last-tagged word handshakes, the next cycle has done=1, busy=0 and state=IDLE.
- Throughput and latency:
  - Start accepted at edge T; the first issue is in cycle T+1; out_valid is 1 from cycle T+2.
  - With out_ready held high, one word per cycle is delivered with no bubbles.
- FIFO behaviour:
  - Pop occurs on out_valid & out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - The count never exceeds 2.
  - out_data/out_last are stable while out_valid=1 and out_ready=0.
- Address wrap: base_addr + len beyond 2^ADDR_W-1 wraps to 0 silently.
- start while busy is ignored; inputs are not re-latched.
- Reset mid-operation returns everything to reset values on the next edge; the FIFO contents are discarded and no done pulse is generated.

Optional Feature:
- Macro: ROM_STREAM_CHECKSUM_EN.
- When defined:
  - Adds output checksum [DATA_W].
  - checksum is the XOR of every word popped in the current burst; cleared to 0 on request acceptance.
  - Its final value is valid and held from the done cycle until the next accepted start; reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package rom_stream_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_READ=2'd1, ST_DRAIN=2'd2;
  - FIFO_DEPTH=2.
- Sub-module rom_stream_fifo2: the 2-entry FIFO of {last, data} with push/pop/count.
- The top level holds the FSM, pointer/counter and ROM drive.

Test Plan:
- ROM holds mem[i]=i; base=0x10, len=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 in consecutive cycles starting 2 cycles after start; out_last on 0x13; done pulse 1 cycle after that handshake.
- base=0x00, len=6, out_ready=0 for 8 cycles then 1 -> exactly 2 ROM issues while stalled, out_data held at 0x00, then all 6 words in order with none dropped or duplicated.
- base=0xFE, len=4 -> rom_address sequence 0xFE,0xFF,0x00,0x01; data matches.
- len=0 -> done at T+1; rom_ce never asserted; busy stays 0. Separately: len=256 with base=0x00 streams all 256 words.
- start pulsed again mid-burst -> ignored. Reset asserted after the 2nd word -> out_valid=0, busy=0, rom_ce=0 next cycle; no done pulse; a fresh start works normally.
- With ROM_STREAM_CHECKSUM_EN and words 0x01,0x02,0x04,0x08 -> checksum=0x0F at done, held until the next start, then cleared.
